// File: rtl/siso_tx_arbiter.sv
// siso_tx_arbiter: round-robin arbiter feeding an MSB-first serial shift-out channel.
// Latency: first bit on dout the cycle after acceptance; frame of WIDTH cycles (+1 parity), then GAP idle cycles.
// Backpressure: a ready is raised only in IDLE; requesters hold valid/data until their ready is seen.
// Optional feature: define PARITY_EN to append one even-parity bit after the data bits of each frame.
module siso_tx_arbiter #(
  parameter int WIDTH = 8,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             dout,
  output logic             frame,
  output logic             busy,
  output logic             grant_id
);

  // One counter serves both the bit index and the gap length.
  localparam int CMAX = (WIDTH > GAP + 1) ? WIDTH : GAP + 1;
  localparam int CW   = $clog2(CMAX);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_GAP
`ifdef PARITY_EN
    , S_PARITY
`endif
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sreg;
  logic             last1;      // last grant went to requester 1
  logic             pick1;
  logic             accept;
  logic [WIDTH-1:0] acc_data;
`ifdef PARITY_EN
  logic             par;
`endif

  // Where a frame goes once its last bit has left: straight to IDLE when there is no gap.
  localparam logic          GAP_ZERO = (GAP == 0);
  localparam logic [CW-1:0] GAP_LOAD = (GAP == 0) ? '0 : CW'(GAP - 1);

  // Round-robin choice and combinational readys, only offered in IDLE and never during reset.
  always_comb begin
    pick1      = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    pick1      = req1_valid && (!req0_valid || !last1);
    if (state == S_IDLE && !rst) begin
      req0_ready = req0_valid && !pick1;
      req1_ready = pick1;
    end
    accept   = req0_ready || req1_ready;
    acc_data = pick1 ? req1_data : req0_data;
  end

  // Frame sequencer: accept, shift MSB-first, optional parity bit, then inter-frame gap.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      sreg     <= '0;
      last1    <= 1'b1;   // so requester 0 wins the first contention
      dout     <= 1'b0;
      frame    <= 1'b0;
      busy     <= 1'b0;
      grant_id <= 1'b0;
`ifdef PARITY_EN
      par      <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            sreg     <= acc_data;
            dout     <= acc_data[WIDTH-1];
            frame    <= 1'b1;
            busy     <= 1'b1;
            grant_id <= pick1;
            last1    <= pick1;
            cnt      <= CW'(WIDTH - 1);
            state    <= S_SHIFT;
`ifdef PARITY_EN
            par      <= ^acc_data;
`endif
          end
        end

        S_SHIFT: begin
          if (cnt != '0) begin
            dout <= sreg[WIDTH-2];
            sreg <= {sreg[WIDTH-2:0], 1'b0};
            cnt  <= cnt - CW'(1);
          end else begin
`ifdef PARITY_EN
            dout  <= par;
            state <= S_PARITY;
`else
            frame <= 1'b0;
            dout  <= 1'b0;
            busy  <= !GAP_ZERO;
            cnt   <= GAP_LOAD;
            state <= GAP_ZERO ? S_IDLE : S_GAP;
`endif
          end
        end

`ifdef PARITY_EN
        S_PARITY: begin
          frame <= 1'b0;
          dout  <= 1'b0;
          busy  <= !GAP_ZERO;
          cnt   <= GAP_LOAD;
          state <= GAP_ZERO ? S_IDLE : S_GAP;
        end
`endif

        S_GAP: begin
          if (cnt == '0) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end

        default: begin
          state <= S_IDLE;
          frame <= 1'b0;
          dout  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_siso_tx_arbiter.sv
// tb_siso_tx_arbiter: directed checks of arbitration, serial framing, gap and reset.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// Build with PARITY_EN defined to exercise the parity-bit frames.
module tb_siso_tx_arbiter;

  localparam int W = 8;
  localparam int G = 1;
`ifdef PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req1_valid;
  logic [W-1:0] req0_data, req1_data;
  logic         req0_ready, req1_ready;
  logic         dout, frame, busy, grant_id;

  int checks = 0;
  int errors = 0;
  bit both_seen = 1'b0;

  always #5 clk = ~clk;

  siso_tx_arbiter #(.WIDTH(W), .GAP(G)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .dout       (dout),
    .frame      (frame),
    .busy       (busy),
    .grant_id   (grant_id)
  );

  always @(posedge clk) if (req0_ready && req1_ready) both_seen = 1'b1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [5:0] outs();
    return {req0_ready, req1_ready, dout, frame, busy, grant_id};
  endfunction

  typedef struct {
    string      nm;
    logic       rst;
    logic       v0;
    logic [7:0] d0;
    logic       v1;
    logic [7:0] d1;
    logic [5:0] exp;   // {ready0, ready1, dout, frame, busy, grant_id}
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input string nm, input logic r, input logic v0, input logic [7:0] d0,
                              input logic v1, input logic [7:0] d1, input logic [5:0] exp);
    vec_t v;
    v.nm = nm; v.rst = r; v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1; v.exp = exp;
    tbl.push_back(v);
  endfunction

  // Checks the NB frame cycles of word w, then the gap cycle; entered and left on a falling edge.
  task automatic frame_check(input logic [7:0] w, input logic g, input bit wiggle);
    logic b;
    for (int i = 0; i < NB; i++) begin
      if (wiggle) begin
        req1_valid = ~req1_valid;
        req0_data  = 8'($urandom);
      end
      #1;
      b = (i < W) ? w[W-1-i] : ^w;
      chk("frame_bit", {frame, dout, grant_id, req0_ready, req1_ready}, {1'b1, b, g, 2'b00});
      @(negedge clk);
    end
    #1;
    chk("gap", {frame, dout, busy}, 3'b001);
    @(negedge clk);
  endtask

  logic [7:0] wb, wc;
  logic [7:0] fw0 [2];
  logic [7:0] fw1 [2];
  logic       exp1;

  initial begin
    rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; req0_data = '0; req1_data = '0;
    fw0[0] = 8'h81; fw0[1] = 8'hC3;
    fw1[0] = 8'h5A; fw1[1] = 8'hF0;
    wb = 8'hB4; wc = 8'h3C;

    // Reset held with both valids, then a lone req0 frame, then a lone req1 frame.
    add("rst_hold", 1, 1, 8'hB4, 1, 8'h3C, 6'b000000);
    add("idle_req0", 0, 1, 8'hB4, 0, 8'h00, 6'b100000);
    for (int i = 0; i < W; i++) add("b4_bit", 0, 0, 8'h00, 0, 8'h00, {2'b00, wb[W-1-i], 3'b110});
`ifdef PARITY_EN
    add("b4_par", 0, 0, 8'h00, 0, 8'h00, {2'b00, ^wb, 3'b110});
`endif
    add("b4_gap", 0, 0, 8'h00, 0, 8'h00, 6'b000010);
    add("b4_idle", 0, 0, 8'h00, 0, 8'h00, 6'b000000);
    add("idle_req1", 0, 0, 8'h00, 1, 8'h3C, 6'b010000);
    for (int i = 0; i < W; i++) add("3c_bit", 0, 0, 8'h00, 0, 8'h00, {2'b00, wc[W-1-i], 3'b111});
`ifdef PARITY_EN
    add("3c_par", 0, 0, 8'h00, 0, 8'h00, {2'b00, ^wc, 3'b111});
`endif
    add("3c_gap", 0, 0, 8'h00, 0, 8'h00, 6'b000011);
    add("gid_hold", 0, 0, 8'h00, 0, 8'h00, 6'b000001);

    @(posedge clk);
    foreach (tbl[k]) begin
      @(negedge clk);
      rst = tbl[k].rst; req0_valid = tbl[k].v0; req0_data = tbl[k].d0;
      req1_valid = tbl[k].v1; req1_data = tbl[k].d1;
      #1;
      chk(tbl[k].nm, outs(), tbl[k].exp);
    end

    // Contention straight after reset: requester 0 first, requester 1 in the next IDLE.
    @(negedge clk);
    rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    req0_valid = 1'b1; req0_data = 8'hA5; req1_valid = 1'b1; req1_data = 8'h3C;
    #1 chk("contend_first", {req0_ready, req1_ready}, 2'b10);
    @(negedge clk);
    req0_valid = 1'b0;
    frame_check(8'hA5, 1'b0, 1'b0);
    #1 chk("contend_second", {req0_ready, req1_ready, busy}, 3'b010);
    @(negedge clk);
    req1_valid = 1'b0;
    frame_check(8'h3C, 1'b1, 1'b0);

    // Both valid continuously: grants alternate 0,1,0,1.
    for (int k = 0; k < 4; k++) begin
      exp1 = k[0];
      req0_valid = 1'b1; req1_valid = 1'b1;
      req0_data = fw0[k/2]; req1_data = fw1[k/2];
      #1 chk("fair_grant", {req0_ready, req1_ready}, exp1 ? 2'b01 : 2'b10);
      @(negedge clk);
      frame_check(exp1 ? fw1[k/2] : fw0[k/2], exp1, 1'b0);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // req1 toggles and req0_data churns while req0's frame is in flight.
    req0_valid = 1'b1; req0_data = 8'h96;
    #1 chk("t5_ready", {req0_ready, req1_ready}, 2'b10);
    @(negedge clk);
    req0_valid = 1'b0;
    frame_check(8'h96, 1'b0, 1'b1);
    req1_valid = 1'b0;
    #1 chk("t5_idle", {req0_ready, req1_ready, frame, busy}, 4'b0000);

    // Reset during the fourth bit of a frame, then the same word restarts from its MSB.
    @(negedge clk);
    req0_valid = 1'b1; req0_data = 8'hB4;
    #1 chk("mid_ready", {req0_ready, req1_ready}, 2'b10);
    @(negedge clk);
    req0_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("mid_bit", {frame, dout}, {1'b1, wb[W-1-i]});
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1 chk("mid_reset", outs(), 6'b000000);
    @(negedge clk);
    req0_valid = 1'b1;
    #1 chk("restart_ready", {req0_ready, req1_ready}, 2'b10);
    @(negedge clk);
    req0_valid = 1'b0;
    frame_check(8'hB4, 1'b0, 1'b0);

    // 0x07: odd parity content, frame length depends on the build.
    req0_valid = 1'b1; req0_data = 8'h07;
    #1 chk("w07_ready", {req0_ready, req1_ready}, 2'b10);
    @(negedge clk);
    req0_valid = 1'b0;
    frame_check(8'h07, 1'b0, 1'b0);
    #1 chk("w07_idle", {frame, busy}, 2'b00);

    chk("never_both_ready", {31'd0, both_seen}, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
